// File: rtl/decode_stage.sv
// Operand-fetch/decode stage feeding the ALU: register file with writeback bypass,
// Beta opcode decode, pending-write scoreboard interlock and execute pipeline register.
module decode_stage #(
   parameter int NREG  = 32,
   parameter bit SB_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [5:0]  ex_fn,
   output logic [4:0]  ex_rc,
   output logic        ex_wr_en,
   output logic        ex_mem_rd,
   output logic        ex_mem_wr,
   output logic [31:0] ex_st_data,
   output logic        ex_illegal,
   output logic [31:0] ex_pc,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data
);
   localparam logic [5:0] FN_ADD = 6'b010000;
   localparam logic [4:0] RZERO  = 5'd31;

   logic [31:0]     regs_reg [NREG];
   logic [NREG-1:0] pend_reg, pend_next, busy;

   logic [5:0]  op;
   logic [4:0]  rc, ra, rb;
   logic [31:0] lit_sext, rd_a, rd_b, rd_c;
   logic        arith, is_reg, is_ld, is_st, illegal, wr_en, hazard, accept;
   logic [5:0]  fn;
   logic [31:0] b_next;

   logic        out_valid_reg, ex_wr_en_reg, ex_mem_rd_reg, ex_mem_wr_reg, ex_illegal_reg;
   logic [31:0] ex_a_reg, ex_b_reg, ex_st_data_reg, ex_pc_reg;
   logic [5:0]  ex_fn_reg;
   logic [4:0]  ex_rc_reg;

   assign op       = in_inst[31:26];
   assign rc       = in_inst[25:21];
   assign ra       = in_inst[20:16];
   assign rb       = in_inst[15:11];
   assign lit_sext = {{16{in_inst[15]}}, in_inst[15:0]};

   // A register being written back this cycle is read as the incoming value.
   function automatic logic [31:0] rd_port(input logic [4:0] addr);
      if (addr == RZERO)
         return '0;
      else if (wb_en && wb_addr == addr)
         return wb_data;
      else
         return regs_reg[addr];
   endfunction

   assign rd_a = rd_port(ra);
   assign rd_b = rd_port(rb);
   assign rd_c = rd_port(rc);

   always_comb begin
      arith = 1'b1;
      fn    = FN_ADD;
      case (op[3:0])
         4'h0: fn = 6'b010000;
         4'h1: fn = 6'b010001;
         4'h4: fn = 6'b000011;
         4'h5: fn = 6'b000101;
         4'h6: fn = 6'b000111;
         4'h8: fn = 6'b101000;
         4'h9: fn = 6'b101100;
         4'hA: fn = 6'b100000;
         4'hC: fn = 6'b110000;
         4'hD: fn = 6'b110001;
         4'hE: fn = 6'b110010;
         default: arith = 1'b0;
      endcase
      // ALU ops live at 0x20-0x2F (register form) and 0x30-0x3F (literal form).
      if (op[5:4] != 2'b10 && op[5:4] != 2'b11)
         arith = 1'b0;
      if (!arith)
         fn = FN_ADD;
      is_ld   = (op == 6'h18);
      is_st   = (op == 6'h19);
      is_reg  = arith && !op[4];
      illegal = !(arith || is_ld || is_st);
      wr_en   = (arith || is_ld) && (rc != RZERO);
      b_next  = is_reg ? rd_b : lit_sext;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_sb
         assign busy[gi] = pend_reg[gi] && !(wb_en && wb_addr == 5'(gi));
         if (gi == NREG - 1) begin : g_zero
            assign pend_next[gi] = 1'b0;
         end else begin : g_pend
            // A new reservation overrides a same-cycle writeback of the same register.
            assign pend_next[gi] = (accept && wr_en && rc == 5'(gi)) || busy[gi];
         end
      end
   endgenerate

   assign hazard   = SB_EN && (busy[ra] || (is_reg && busy[rb]) || ((is_st || wr_en) && busy[rc]));
   assign in_ready = !hazard && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs_reg[i] <= '0;
         pend_reg <= '0;
      end else begin
         if (wb_en && wb_addr != RZERO)
            regs_reg[wb_addr] <= wb_data;
         pend_reg <= pend_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         ex_a_reg       <= '0;
         ex_b_reg       <= '0;
         ex_fn_reg      <= '0;
         ex_rc_reg      <= '0;
         ex_wr_en_reg   <= 1'b0;
         ex_mem_rd_reg  <= 1'b0;
         ex_mem_wr_reg  <= 1'b0;
         ex_st_data_reg <= '0;
         ex_illegal_reg <= 1'b0;
         ex_pc_reg      <= '0;
      end else if (accept) begin
         out_valid_reg  <= 1'b1;
         ex_a_reg       <= rd_a;
         ex_b_reg       <= b_next;
         ex_fn_reg      <= fn;
         ex_rc_reg      <= rc;
         ex_wr_en_reg   <= wr_en;
         ex_mem_rd_reg  <= is_ld;
         ex_mem_wr_reg  <= is_st;
         ex_st_data_reg <= rd_c;
         ex_illegal_reg <= illegal;
         ex_pc_reg      <= in_pc;
      end else if (out_ready) begin
         out_valid_reg  <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign ex_a       = ex_a_reg;
   assign ex_b       = ex_b_reg;
   assign ex_fn      = ex_fn_reg;
   assign ex_rc      = ex_rc_reg;
   assign ex_wr_en   = ex_wr_en_reg;
   assign ex_mem_rd  = ex_mem_rd_reg;
   assign ex_mem_wr  = ex_mem_wr_reg;
   assign ex_st_data = ex_st_data_reg;
   assign ex_illegal = ex_illegal_reg;
   assign ex_pc      = ex_pc_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven opcode vectors, directed hazard/stall/reset
// sequences and a randomized run, all scored against a per-cycle reference model.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc;
   logic [31:0] ex_a, ex_b, ex_st_data, ex_pc;
   logic [5:0]  ex_fn;
   logic [4:0]  ex_rc;
   logic        ex_wr_en, ex_mem_rd, ex_mem_wr, ex_illegal;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   decode_stage #(.NREG(32), .SB_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .ex_a(ex_a), .ex_b(ex_b), .ex_fn(ex_fn), .ex_rc(ex_rc),
      .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_st_data(ex_st_data), .ex_illegal(ex_illegal), .ex_pc(ex_pc),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mregs [32];
   bit          mpend [32];
   int          fn_of [64];
   bit          m_valid, m_wr, m_rd, m_mw, m_ill;
   logic [31:0] m_a, m_b, m_st, m_pc;
   logic [5:0]  m_fn;
   logic [4:0]  m_rc;
   logic [31:0] pc_ctr = 32'h1000;

   typedef struct {
      logic [31:0] inst;
      logic [5:0]  fn;
      bit          ill, wr, mrd, mwr;
   } vec_t;
   vec_t vecs [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [4:0] rb);
      return {op, rc, ra, rb, 11'b0};
   endfunction

   function automatic logic [31:0] enc_l(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [15:0] lit);
      return {op, rc, ra, lit};
   endfunction

   function automatic logic [31:0] mread(input int a, input bit we, input int wa,
                                         input logic [31:0] wd);
      if (a == 31) return 32'h0;
      if (we && wa == a) return wd;
      return mregs[a];
   endfunction

   function automatic bit mbusy(input int s, input bit we, input int wa);
      return (s != 31) && mpend[s] && !(we && wa == s);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = '0;
         mpend[i] = 1'b0;
      end
      m_valid = 0; m_wr = 0; m_rd = 0; m_mw = 0; m_ill = 0;
      m_a = '0; m_b = '0; m_st = '0; m_pc = '0; m_fn = '0; m_rc = '0;
   endtask

   // One clock of stimulus: check in_ready before the edge, every output after it.
   task automatic cycle(input bit iv, input logic [31:0] inst, input bit ord,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        output bit accepted);
      int op, rc, ra, rb, f;
      bit arith, ld, st, isreg, wr, haz, rdy;
      logic [31:0] ea, eb, est;
      in_valid = iv; in_inst = inst; in_pc = pc_ctr; out_ready = ord;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      op = int'(inst[31:26]); rc = int'(inst[25:21]);
      ra = int'(inst[20:16]); rb = int'(inst[15:11]);
      f = fn_of[op];
      arith = (f >= 0);
      ld = (op == 'h18);
      st = (op == 'h19);
      isreg = arith && op < 'h30;
      wr = (arith || ld) && rc != 31;
      ea = mread(ra, we, int'(wa), wd);
      eb = isreg ? mread(rb, we, int'(wa), wd) : {{16{inst[15]}}, inst[15:0]};
      est = mread(rc, we, int'(wa), wd);
      haz = mbusy(ra, we, int'(wa)) || (isreg && mbusy(rb, we, int'(wa))) ||
            ((st || wr) && mbusy(rc, we, int'(wa)));
      rdy = !haz && (!m_valid || ord);
      chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
      accepted = iv && rdy;
      if (accepted)
         $display("xact pc=%h inst=%h", pc_ctr, inst);
      @(posedge clk);
      if (we && wa != 5'd31) mregs[wa] = wd;
      if (we) mpend[wa] = 1'b0;
      if (accepted && wr) mpend[rc] = 1'b1;
      if (accepted) begin
         m_valid = 1; m_a = ea; m_b = eb; m_st = est; m_pc = pc_ctr;
         m_fn = arith ? 6'(f) : 6'b010000;
         m_rc = 5'(rc); m_wr = wr; m_rd = ld; m_mw = st; m_ill = !(arith || ld || st);
         pc_ctr = pc_ctr + 4;
      end else if (ord) begin
         m_valid = 0;
      end
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) begin
         if (!m_ill) begin
            chk("ex_a", ex_a, m_a);
            chk("ex_b", ex_b, m_b);
         end
         chk("ex_fn", {26'b0, ex_fn}, {26'b0, m_fn});
         chk("ex_rc", {27'b0, ex_rc}, {27'b0, m_rc});
         chk("ex_wr_en", {31'b0, ex_wr_en}, {31'b0, m_wr});
         chk("ex_mem_rd", {31'b0, ex_mem_rd}, {31'b0, m_rd});
         chk("ex_mem_wr", {31'b0, ex_mem_wr}, {31'b0, m_mw});
         chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ill});
         chk("ex_pc", ex_pc, m_pc);
         if (m_mw) chk("ex_st_data", ex_st_data, m_st);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 0; out_ready = 1; wb_en = 0; wb_addr = '0; wb_data = '0;
      in_inst = '0; in_pc = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   bit acc;
   logic [31:0] held_pc, cur_inst;
   bit pending_inst;

   initial begin
      // ALU function table; literal forms sit 0x10 above their register forms
      for (int i = 0; i < 64; i++) fn_of[i] = -1;
      fn_of['h20] = 'b010000; fn_of['h21] = 'b010001;
      fn_of['h24] = 'b000011; fn_of['h25] = 'b000101; fn_of['h26] = 'b000111;
      fn_of['h28] = 'b101000; fn_of['h29] = 'b101100; fn_of['h2A] = 'b100000;
      fn_of['h2C] = 'b110000; fn_of['h2D] = 'b110001; fn_of['h2E] = 'b110010;
      for (int i = 'h20; i < 'h30; i++) fn_of[i + 'h10] = fn_of[i];

      vecs[0]  = '{enc_r(6'h20, 5'd8,  5'd1, 5'd2),     6'b010000, 0, 1, 0, 0};
      vecs[1]  = '{enc_r(6'h21, 5'd9,  5'd1, 5'd2),     6'b010001, 0, 1, 0, 0};
      vecs[2]  = '{enc_r(6'h24, 5'd10, 5'd1, 5'd2),     6'b000011, 0, 1, 0, 0};
      vecs[3]  = '{enc_r(6'h25, 5'd11, 5'd1, 5'd2),     6'b000101, 0, 1, 0, 0};
      vecs[4]  = '{enc_r(6'h26, 5'd12, 5'd1, 5'd2),     6'b000111, 0, 1, 0, 0};
      vecs[5]  = '{enc_r(6'h28, 5'd13, 5'd1, 5'd2),     6'b101000, 0, 1, 0, 0};
      vecs[6]  = '{enc_r(6'h29, 5'd14, 5'd1, 5'd2),     6'b101100, 0, 1, 0, 0};
      vecs[7]  = '{enc_r(6'h2A, 5'd15, 5'd1, 5'd2),     6'b100000, 0, 1, 0, 0};
      vecs[8]  = '{enc_r(6'h2C, 5'd16, 5'd1, 5'd2),     6'b110000, 0, 1, 0, 0};
      vecs[9]  = '{enc_r(6'h2D, 5'd17, 5'd1, 5'd2),     6'b110001, 0, 1, 0, 0};
      vecs[10] = '{enc_r(6'h2E, 5'd18, 5'd1, 5'd2),     6'b110010, 0, 1, 0, 0};
      vecs[11] = '{enc_l(6'h30, 5'd19, 5'd1, 16'hFFF8), 6'b010000, 0, 1, 0, 0};
      vecs[12] = '{enc_l(6'h35, 5'd20, 5'd1, 16'h0003), 6'b000101, 0, 1, 0, 0};
      vecs[13] = '{enc_l(6'h3A, 5'd21, 5'd1, 16'h8000), 6'b100000, 0, 1, 0, 0};
      vecs[14] = '{enc_l(6'h18, 5'd22, 5'd1, 16'h0010), 6'b010000, 0, 1, 1, 0};
      vecs[15] = '{enc_l(6'h19, 5'd23, 5'd1, 16'h0004), 6'b010000, 0, 0, 0, 1};
      vecs[16] = '{enc_l(6'h3F, 5'd24, 5'd1, 16'h0000), 6'b010000, 1, 0, 0, 0};
      vecs[17] = '{enc_r(6'h22, 5'd25, 5'd1, 5'd2),     6'b010000, 1, 0, 0, 0};

      do_reset();
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_ex_a", ex_a, 32'h0);
      chk("rst_ex_b", ex_b, 32'h0);
      chk("rst_ex_fn", {26'b0, ex_fn}, 32'h0);
      chk("rst_ex_pc", ex_pc, 32'h0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

      cycle(0, 32'h0, 1, 1, 5'd1, 32'd5, acc);
      cycle(0, 32'h0, 1, 1, 5'd2, 32'd7, acc);
      cycle(1, 32'h80611000, 1, 0, 5'd0, 32'd0, acc);
      chk("add_a", ex_a, 32'd5);
      chk("add_b", ex_b, 32'd7);
      chk("add_fn", {26'b0, ex_fn}, 32'b010000);
      chk("add_wr", {31'b0, ex_wr_en}, 32'h1);
      cycle(1, enc_l(6'h30, 5'd4, 5'd31, 16'hFFFF), 1, 0, 5'd0, 32'd0, acc);
      chk("addc_a", ex_a, 32'h0);
      chk("addc_b", ex_b, 32'hFFFFFFFF);
      cycle(1, enc_r(6'h25, 5'd5, 5'd1, 5'd2), 1, 0, 5'd0, 32'd0, acc);
      chk("cmplt_fn", {26'b0, ex_fn}, 32'b000101);

      // RAW hazard on r3, released by a bypassed writeback
      cycle(0, 32'h0, 1, 1, 5'd3, 32'd0, acc);
      cycle(1, 32'h80611000, 1, 0, 5'd0, 32'd0, acc);
      for (int i = 0; i < 2; i++) begin
         cycle(1, enc_r(6'h21, 5'd6, 5'd3, 5'd1), 1, 0, 5'd0, 32'd0, acc);
         chk("raw_stall", {31'b0, acc}, 32'h0);
      end
      cycle(1, enc_r(6'h21, 5'd6, 5'd3, 5'd1), 1, 1, 5'd3, 32'd12, acc);
      chk("raw_accept", {31'b0, acc}, 32'h1);
      chk("raw_bypass_a", ex_a, 32'd12);
      chk("raw_sub_fn", {26'b0, ex_fn}, 32'b010001);

      // Downstream backpressure holds the execute register
      cycle(1, enc_l(6'h3A, 5'd30, 5'd2, 16'h0003), 1, 0, 5'd0, 32'd0, acc);
      held_pc = ex_pc;
      for (int i = 0; i < 3; i++) begin
         cycle(1, enc_l(6'h30, 5'd7, 5'd1, 16'h0005), 0, 0, 5'd0, 32'd0, acc);
         chk("hold_pc", ex_pc, held_pc);
         chk("hold_no_accept", {31'b0, acc}, 32'h0);
      end
      cycle(1, enc_l(6'h30, 5'd7, 5'd1, 16'h0005), 1, 0, 5'd0, 32'd0, acc);
      chk("release_b", ex_b, 32'd5);

      cycle(1, enc_l(6'h19, 5'd1, 5'd2, 16'h0008), 1, 0, 5'd0, 32'd0, acc);
      chk("st_data", ex_st_data, 32'd5);
      chk("st_b", ex_b, 32'd8);
      chk("st_mem_wr", {31'b0, ex_mem_wr}, 32'h1);
      chk("st_wr_en", {31'b0, ex_wr_en}, 32'h0);
      cycle(1, enc_l(6'h3F, 5'd9, 5'd1, 16'h0000), 1, 0, 5'd0, 32'd0, acc);
      chk("ill_flag", {31'b0, ex_illegal}, 32'h1);
      chk("ill_wr_en", {31'b0, ex_wr_en}, 32'h0);

      foreach (vecs[i]) begin
         cycle(1, vecs[i].inst, 1, 0, 5'd0, 32'd0, acc);
         chk("vec_accept", {31'b0, acc}, 32'h1);
         chk("vec_fn", {26'b0, ex_fn}, {26'b0, vecs[i].fn});
         chk("vec_illegal", {31'b0, ex_illegal}, {31'b0, vecs[i].ill});
         chk("vec_wr_en", {31'b0, ex_wr_en}, {31'b0, vecs[i].wr});
         chk("vec_mem_rd", {31'b0, ex_mem_rd}, {31'b0, vecs[i].mrd});
         chk("vec_mem_wr", {31'b0, ex_mem_wr}, {31'b0, vecs[i].mwr});
      end

      // Randomized traffic over a small register window to provoke hazards
      pending_inst = 0;
      cur_inst = '0;
      for (int n = 0; n < 500; n++) begin
         logic [4:0] r [3];
         logic [5:0] op;
         logic [4:0] wa;
         if (!pending_inst) begin
            for (int k = 0; k < 3; k++)
               r[k] = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
            case ($urandom_range(0, 5))
               0: op = 6'h18;
               1: op = 6'h19;
               2: op = 6'($urandom);
               default: op = 6'($urandom_range('h20, 'h3F));
            endcase
            cur_inst = {op, r[0], r[1], r[2], 11'($urandom)};
         end
         wa = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
         cycle($urandom_range(0, 4) != 0, cur_inst, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 4, wa, $urandom, acc);
         pending_inst = !acc;
      end

      // Asynchronous reset while an op is held and r3 is reserved
      do_reset();
      cycle(0, 32'h0, 1, 1, 5'd1, 32'd5, acc);
      cycle(0, 32'h0, 1, 1, 5'd2, 32'd7, acc);
      cycle(1, 32'h80611000, 0, 0, 5'd0, 32'd0, acc);
      chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
      in_valid = 1; in_inst = enc_r(6'h21, 5'd6, 5'd3, 5'd1); out_ready = 0; wb_en = 0;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("async_rst_ex_rc", {27'b0, ex_rc}, 32'h0);
      chk("async_rst_ready", {31'b0, in_ready}, 32'h1);
      model_clear();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1, enc_r(6'h21, 5'd6, 5'd3, 5'd1), 1, 0, 5'd0, 32'd0, acc);
      chk("post_rst_accept", {31'b0, acc}, 32'h1);
      chk("post_rst_rc", {27'b0, ex_rc}, 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Operand-fetch/decode stage that sits directly upstream of the 32-bit ALU.
- Accepts one Beta-format instruction per handshake, reads the 32x32 register file and builds the ALU operands a/b plus the 6-bit ALU fn code.
- Registers the result into the execute-stage pipeline register.
- Holds a per-register pending scoreboard and stalls on RAW/WAW hazards until writeback clears them.

Parameters:
- NREG, 32, register count; fixed at 32, R31 hardwired zero.
- SB_EN, 1, 1 = scoreboard interlock active; 0 = never stall on hazards (bring-up only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept this cycle.
- in_inst  input  32  instruction: op[31:26] rc[25:21] ra[20:16] rb[15:11] lit[15:0].
- in_pc  input  32  PC of instruction.
- out_valid  output  1  execute register holds a valid op.
- out_ready  input  1  execute stage consumes.
- ex_a  output  32  ALU operand a (Reg[ra]).
- ex_b  output  32  ALU operand b (Reg[rb] or sign-extended lit).
- ex_fn  output  6  ALU function code.
- ex_rc  output  5  destination register.
- ex_wr_en  output  1  result written back.
- ex_mem_rd  output  1  load.
- ex_mem_wr  output  1  store.
- ex_st_data  output  32  Reg[rc] for stores.
- ex_illegal  output  1  unsupported opcode.
- ex_pc  output  32  PC passthrough.
- wb_en  input  1  writeback strobe.
- wb_addr  input  5  writeback register.
- wb_data  input  32  writeback value.

Behaviour:
- Reset (async, rst=1): out_valid=0, all ex_* = 0, all 32 registers = 0, pending = 0. Deassertion is synchronous to clk by the surrounding logic.
- Decode, register form (op 0x20-0x2E) and literal form (same op + 0x10, b = sext(lit)):
  - ADD 0x20 -> fn 010000; SUB 0x21 -> 010001.
  - CMPEQ 0x24 -> 000011; CMPLT 0x25 -> 000101; CMPLE 0x26 -> 000111.
  - AND 0x28 -> 101000; OR 0x29 -> 101100; XOR 0x2A -> 100000.
  - SHL 0x2C -> 110000; SHR 0x2D -> 110001; SRA 0x2E -> 110010.
- LD 0x18: fn ADD, b = sext(lit), mem_rd=1, wr_en=1.
- ST 0x19: fn ADD, b = sext(lit), mem_wr=1, wr_en=0, st_data = Reg[rc].
- Any other op: illegal=1, wr_en=0, mem_rd/mem_wr=0, fn=010000; still passed downstream.
- wr_en forced to 0 when rc=31.
- Register reads: R31 reads 0. Write-through: if wb_en and wb_addr equals the read address (not 31), the read returns wb_data in the same cycle. Writes to R31 are ignored.
- Sources used for hazards:
  - ra: always.
  - rb: register-form ops only.
  - rc: ST only.
  - Any source equal to 31 is never a hazard.
- hazard (SB_EN=1) when, for any used source s, pending[s] && !(wb_en && wb_addr==s). A WAW hazard applies the same test to rc when wr_en=1.
- in_ready = !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready. Single-cycle latency: accepted instruction appears on ex_* with out_valid=1 next edge.
- Output register:
  - On accept: load ex_*, out_valid=1.
  - Else if out_ready: out_valid=0.
  - While out_valid && !out_ready, ex_* are held stable.
- Scoreboard:
  - wb_en clears pending[wb_addr].
  - Accept with wr_en sets pending[rc].
  - Same-cycle set and clear of the same register: set wins.
  - pending[31] is always 0.
- in_valid deasserted mid-stall: no state change; no instruction is lost or duplicated.
- Reset mid-operation: in-flight op is dropped and the scoreboard is cleared immediately.

Test Plan:
- After reset, write R1=5 and R2=7 via wb, then issue ADD r3,r1,r2 (0x80611000) -> next cycle out_valid=1, ex_a=5, ex_b=7, ex_fn=010000, ex_rc=3, ex_wr_en=1.
- Issue ADDC r4,r31,-1 (lit 0xFFFF) -> ex_a=0, ex_b=0xFFFFFFFF, fn=010000. Issue CMPLT r5,r1,r2 -> fn=000101.
- Issue ADD r3,r1,r2 and then SUB r6,r3,r1 back-to-back -> in_ready=0 until wb_en with wb_addr=3 and wb_data=12. In that wb cycle SUB is accepted and ex_a=12 via bypass.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> ex_* stable, in_ready=0, no drop. Release -> next instruction appears in the following cycle.
- Issue ST r1 at lit 8 from r2 -> mem_wr=1, wr_en=0, ex_st_data=Reg[1], ex_b=8. Issue op 0x3F -> ex_illegal=1, ex_wr_en=0.
- Assert rst with pending[3]=1 and out_valid=1 -> out_valid=0 and pending=0 immediately. After release, SUB r6,r3,r1 is accepted without stall.
